// File: rtl/controlador_botoes_pkg.sv
`default_nettype none
// ============================================================================
// controlador_botoes_pkg : command codes, FSM states and a saturating helper
// Rev 1.0
// ============================================================================
package controlador_botoes_pkg;

  localparam logic [1:0] CMD_NENHUM = 2'b00;
  localparam logic [1:0] CMD_COMER  = 2'b01;
  localparam logic [1:0] CMD_DORMIR = 2'b10;
  localparam logic [1:0] CMD_AULA   = 2'b11;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    ESPERA_COMBO = 2'b01,
    SEGURANDO    = 2'b10
  } estado_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/controlador_botoes_if.sv
`default_nettype none
// ============================================================================
// controlador_botoes_if : raw button inputs and command outputs
// Rev 1.0
// ============================================================================
interface controlador_botoes_if;
  logic       b1_raw;
  logic       b2_raw;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       busy;

  modport master (output b1_raw, output b2_raw,
                  input cmd_valid, input cmd, input busy);
  modport slave  (input b1_raw, input b2_raw,
                  output cmd_valid, output cmd, output busy);
endinterface
`default_nettype wire

// File: rtl/controlador_botoes_debouncer.sv
`default_nettype none
// ============================================================================
// debouncer_botao : per-button stability debouncer with press strobe output
// Optional 2-flop input synchronizer under macro BTN_SYNC_EN.   Rev 1.0
// ============================================================================
module debouncer_botao
  import controlador_botoes_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  logic raw_s;

`ifdef BTN_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], raw_i};
  end
  assign raw_s = sync_q[1];
`else
  assign raw_s = raw_i;
`endif

  logic [15:0] cnt_q, cnt_d;
  logic        level_q, level_d;
  logic        prev_q;

  // Counter runs only while raw disagrees with the accepted level.
  always_comb begin
    cnt_d   = 16'd0;
    level_d = level_q;
    if (raw_s != level_q) begin
      cnt_d = sat_inc16(cnt_q);
      if (cnt_d >= DEBOUNCE_CYCLES) begin
        level_d = raw_s;
        cnt_d   = 16'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 16'd0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= level_q;
    end
  end

  assign level_o = level_q;
  assign press_o = level_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/controlador_botoes.sv
`default_nettype none
// ============================================================================
// controlador_botoes : two-button debounce + single/combo command decoder
// Macro BTN_SYNC_EN adds input synchronizers inside the debouncers. Rev 1.0
// ============================================================================
module controlador_botoes
  import controlador_botoes_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [15:0] COMBO_WINDOW    = 16'd25000
) (
  input  logic                 clk,
  input  logic                 rst,
  controlador_botoes_if.slave  bus
);

  logic lvl1, lvl2, prs1, prs2;

  debouncer_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b1 (
    .clk(clk), .rst(rst), .raw_i(bus.b1_raw), .level_o(lvl1), .press_o(prs1)
  );

  debouncer_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b2 (
    .clk(clk), .rst(rst), .raw_i(bus.b2_raw), .level_o(lvl2), .press_o(prs2)
  );

  estado_t     state_q, state_d;
  logic        btn_q, btn_d;       // 0 = b1 recorded, 1 = b2 recorded
  logic [15:0] win_q, win_d;
  logic        valid_q, valid_d;
  logic [1:0]  cmd_q, cmd_d;

  logic       other_press, rec_level;
  logic [1:0] single_cmd;

  assign other_press = btn_q ? prs1 : prs2;
  assign rec_level   = btn_q ? lvl2 : lvl1;
  assign single_cmd  = btn_q ? CMD_DORMIR : CMD_COMER;

  always_comb begin
    state_d = state_q;
    btn_d   = btn_q;
    win_d   = win_q;
    valid_d = 1'b0;
    cmd_d   = cmd_q;
    case (state_q)
      IDLE: begin
        if (prs1 && prs2) begin
          valid_d = 1'b1;
          cmd_d   = CMD_AULA;
          state_d = SEGURANDO;
        end else if (prs1 || prs2) begin
          btn_d   = prs2;
          win_d   = 16'd0;
          state_d = ESPERA_COMBO;
        end
      end
      ESPERA_COMBO: begin
        win_d = sat_inc16(win_q);
        // Combo beats both release and expiry when they coincide.
        if (other_press && (win_q < COMBO_WINDOW)) begin
          valid_d = 1'b1;
          cmd_d   = CMD_AULA;
          state_d = SEGURANDO;
        end else if (!rec_level || (win_d >= COMBO_WINDOW)) begin
          valid_d = 1'b1;
          cmd_d   = single_cmd;
          state_d = SEGURANDO;
        end
      end
      SEGURANDO: begin
        if (!lvl1 && !lvl2) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      btn_q   <= 1'b0;
      win_q   <= 16'd0;
      valid_q <= 1'b0;
      cmd_q   <= CMD_NENHUM;
    end else begin
      state_q <= state_d;
      btn_q   <= btn_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      cmd_q   <= cmd_d;
    end
  end

  assign bus.cmd_valid = valid_q;
  assign bus.cmd       = cmd_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: doc/controlador_botoes.md
CONTROLADOR_BOTOES -- requirements
Module: controlador_botoes

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16'd50000: consecutive stable cycles needed to accept a new button level.
REQ-002 SHALL have parameter COMBO_WINDOW, default 16'd25000: cycles after a first press during which a second press forms a combo.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on posedge clk.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port b1_raw, input, 1: raw button 1, bouncy, active-high.
REQ-006 SHALL have port b2_raw, input, 1: raw button 2, bouncy, active-high.
REQ-007 SHALL have port cmd_valid, output, 1: one-cycle pulse marking a new command.
REQ-008 SHALL have port cmd, output, 2: command code; 2'b01 COMER, 2'b10 DORMIR, 2'b11 AULA, 2'b00 NENHUM; meaningful only while cmd_valid=1.
REQ-009 SHALL have port busy, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-010 SHALL debounce each button independently.
- A debounced level changes only after the raw input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
- The stability counter clears whenever the raw input equals the debounced level.
REQ-011 SHALL detect a press as a registered rising edge of a debounced level, giving a 1-cycle press strobe.
REQ-012 SHALL implement the FSM states IDLE, ESPERA_COMBO and SEGURANDO.
REQ-013 IDLE transitions:
- Exactly one press strobe: record the button, clear the window counter, go to ESPERA_COMBO.
- Both press strobes in the same cycle: emit AULA, go to SEGURANDO.
REQ-014 ESPERA_COMBO: the window counter increments every cycle.
REQ-015 ESPERA_COMBO, press strobe of the other button while counter < COMBO_WINDOW: emit AULA, go to SEGURANDO.
REQ-016 ESPERA_COMBO, recorded button released (debounced low) before the window expires: emit its single command (b1 gives COMER, b2 gives DORMIR), go to SEGURANDO.
REQ-017 ESPERA_COMBO, counter reaches COMBO_WINDOW: emit the recorded single command, go to SEGURANDO.
REQ-018 ESPERA_COMBO, release and other-button press in the same cycle: AULA wins.
REQ-019 SEGURANDO: emit nothing; return to IDLE only when both debounced levels are 0.
REQ-020 Emission timing:
- cmd_valid SHALL go high in the cycle after the deciding event, for exactly one cycle.
- cmd SHALL hold its last value afterwards.
REQ-021 SHALL emit at most one command per press episode; an episode runs from leaving IDLE back to IDLE.
REQ-022 Counters SHALL saturate and never wrap; width SHALL be 16 bits.

Reset
REQ-023 rst=1 at a clock edge SHALL force:
- state IDLE, cmd_valid=0, cmd=2'b00, busy=0;
- all counters to 0, debounced levels and edge registers to 0.
REQ-024 Reset mid-episode SHALL abort the episode with no command emitted; a button still held after reset SHALL count as a new press once debounced.

Configuration
REQ-025 With macro BTN_SYNC_EN defined, each raw input SHALL pass through a 2-flop synchronizer before the debouncer, adding 2 cycles of latency; its flops reset to 0.
REQ-026 With BTN_SYNC_EN undefined, raw inputs SHALL feed the debouncers directly.

Structure
REQ-027 A shared package SHALL hold the command codes (CMD_NENHUM, CMD_COMER, CMD_DORMIR, CMD_AULA) and the FSM state encodings.
REQ-028 SHALL instantiate sub-module debouncer_botao twice, one per button.
- debouncer_botao contains the stability counter and the registered level.
- It contains the optional synchronizer under BTN_SYNC_EN.

Verification (DEBOUNCE_CYCLES=4, COMBO_WINDOW=8, BTN_SYNC_EN undefined)
REQ-029 Clean b1 press, held 20 cycles, then released -> exactly one cmd_valid pulse with cmd=01, 9 cycles after the debounced press.
REQ-030 b1 press, then b2 press 3 cycles later, both held -> one pulse with cmd=11; no 01 pulse.
REQ-031 b2 bounces (1,0,1,0 every cycle), then held stable -> no strobe during bouncing; one DORMIR (10) after the window; busy=1 until both are released.
REQ-032 b1 and b2 rise in the same cycle -> cmd=11, one cycle after the simultaneous debounced press.
REQ-033 rst asserted during ESPERA_COMBO -> cmd_valid stays 0; state is IDLE next cycle; a held button yields one new command after re-debounce.
REQ-034 b2 pressed 2 cycles after the b1 window expired -> only cmd=01; the b2 press is ignored until both are released.
